// File: rtl/weight_buffer_ctrl.sv
// weight_buffer_ctrl
//   Sequences weight loading from memory into the per-kernel weight buffers.
//   Each kernel group takes NUM_RDATA consecutive rows. Every returned row is
//   split into NUM_KERNEL slices and shifted into the buffers. The group is
//   then released to the compute engine once it reports ready.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_start               one-cycle start pulse (ignored while busy)
//   i_cfg_base_addr       first row address, latched on accepted start
//   i_cfg_num_grp         number of kernel groups, latched on accepted start
//   o_mem_rd_en/o_mem_addr    memory read request, one row per cycle
//   i_mem_rd_data/i_mem_rd_val  in-order read return, latency >= 1
//   o_data_knK/o_data_knK_val   per-kernel row and shift-in strobe (K = 0..3)
//   i_pe_ready            compute engine can take a full kernel group
//   o_data_req            one-cycle release pulse to the PEs
//   o_busy, o_done, o_err status (o_err is sticky until reset)
//
// States
//   state     | meaning
//   S_IDLE    | waiting for i_start
//   S_FETCH   | issuing NUM_RDATA reads and collecting their return beats
//   S_WAIT_PE | group buffered, waiting for i_pe_ready
//   S_ISSUE   | o_data_req pulse, advance group counter
//   S_DONE    | o_done pulse, back to idle
module weight_buffer_ctrl #(
    parameter int DAT_WIDTH   = 8,
    parameter int NUM_KERNEL  = 4,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_RDATA   = 3,
    parameter int ADDR_WIDTH  = 16,
    parameter int GRP_WIDTH   = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_start,
    input  logic [ADDR_WIDTH-1:0]                     i_cfg_base_addr,
    input  logic [GRP_WIDTH-1:0]                      i_cfg_num_grp,
    output logic                                      o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                     o_mem_addr,
    input  logic [DAT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_mem_rd_data,
    input  logic                                      i_mem_rd_val,
    output logic [DAT_WIDTH*NUM_CHANNEL-1:0]          o_data_kn0,
    output logic [DAT_WIDTH*NUM_CHANNEL-1:0]          o_data_kn1,
    output logic [DAT_WIDTH*NUM_CHANNEL-1:0]          o_data_kn2,
    output logic [DAT_WIDTH*NUM_CHANNEL-1:0]          o_data_kn3,
    output logic                                      o_data_kn0_val,
    output logic                                      o_data_kn1_val,
    output logic                                      o_data_kn2_val,
    output logic                                      o_data_kn3_val,
    input  logic                                      i_pe_ready,
    output logic                                      o_data_req,
    output logic                                      o_busy,
    output logic                                      o_done,
    output logic                                      o_err
);

    localparam int KW    = DAT_WIDTH * NUM_CHANNEL;
    localparam int CNT_W = $clog2(NUM_RDATA + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(NUM_RDATA - 1);
    localparam logic [CNT_W-1:0] RD_ALL  = CNT_W'(NUM_RDATA);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_PE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_addr;   // address of the next read to issue
    logic [GRP_WIDTH-1:0]  num_grp;
    logic [GRP_WIDTH-1:0]  grp_cnt;
    logic [GRP_WIDTH-1:0]  grp_next;
    logic [CNT_W-1:0]      rd_left;     // reads still to issue after the current one
    logic [CNT_W-1:0]      beat_left;   // return beats still expected in this group
    logic                  beat_ok;

    assign grp_next = grp_cnt + 1'b1;

    // A beat is only usable while fetching and still owed to the current group.
    assign beat_ok = i_mem_rd_val && (state == S_FETCH) && (beat_left != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            next_addr      <= '0;
            num_grp        <= '0;
            grp_cnt        <= '0;
            rd_left        <= '0;
            beat_left      <= '0;
            o_mem_rd_en    <= 1'b0;
            o_mem_addr     <= '0;
            o_data_kn0     <= '0;
            o_data_kn1     <= '0;
            o_data_kn2     <= '0;
            o_data_kn3     <= '0;
            o_data_kn0_val <= 1'b0;
            o_data_kn1_val <= 1'b0;
            o_data_kn2_val <= 1'b0;
            o_data_kn3_val <= 1'b0;
            o_data_req     <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            o_data_kn0_val <= 1'b0;
            o_data_kn1_val <= 1'b0;
            o_data_kn2_val <= 1'b0;
            o_data_kn3_val <= 1'b0;
            o_data_req     <= 1'b0;
            o_done         <= 1'b0;

            if (i_mem_rd_val && !beat_ok) begin
                o_err <= 1'b1;
            end

            if (beat_ok) begin
                o_data_kn0     <= i_mem_rd_data[0*KW +: KW];
                o_data_kn1     <= i_mem_rd_data[1*KW +: KW];
                o_data_kn2     <= i_mem_rd_data[2*KW +: KW];
                o_data_kn3     <= i_mem_rd_data[3*KW +: KW];
                o_data_kn0_val <= 1'b1;
                o_data_kn1_val <= 1'b1;
                o_data_kn2_val <= 1'b1;
                o_data_kn3_val <= 1'b1;
                beat_left      <= beat_left - 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        num_grp <= i_cfg_num_grp;
                        grp_cnt <= '0;
                        o_busy  <= 1'b1;
                        if (i_cfg_num_grp != '0) begin
                            state       <= S_FETCH;
                            o_mem_rd_en <= 1'b1;
                            o_mem_addr  <= i_cfg_base_addr;
                            next_addr   <= i_cfg_base_addr + 1'b1;
                            rd_left     <= RD_LAST;
                            beat_left   <= RD_ALL;
                        end else begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    if (rd_left != '0) begin
                        o_mem_rd_en <= 1'b1;
                        o_mem_addr  <= next_addr;
                        next_addr   <= next_addr + 1'b1;
                        rd_left     <= rd_left - 1'b1;
                    end else begin
                        o_mem_rd_en <= 1'b0;
                    end
                    if (beat_ok && beat_left == CNT_ONE) begin
                        state <= S_WAIT_PE;
                    end
                end

                S_WAIT_PE: begin
                    if (i_pe_ready) begin
                        state      <= S_ISSUE;
                        o_data_req <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    grp_cnt <= grp_next;
                    if (grp_next == num_grp) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end else begin
                        // Address keeps running from the previous group.
                        state       <= S_FETCH;
                        o_mem_rd_en <= 1'b1;
                        o_mem_addr  <= next_addr;
                        next_addr   <= next_addr + 1'b1;
                        rd_left     <= RD_LAST;
                        beat_left   <= RD_ALL;
                    end
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Scoreboard bench for weight_buffer_ctrl: a start pushes the expected read
// addresses, kernel rows and completion record; a monitor compares what the
// DUT presents against those queues.
module tb_weight_buffer_ctrl;
    localparam int DW    = 96;
    localparam int NROWS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [15:0]   i_cfg_base_addr = '0;
    logic [7:0]    i_cfg_num_grp = '0;
    logic          o_mem_rd_en;
    logic [15:0]   o_mem_addr;
    logic [DW-1:0] i_mem_rd_data;
    logic          i_mem_rd_val;
    logic [23:0]   o_data_kn0, o_data_kn1, o_data_kn2, o_data_kn3;
    logic          o_data_kn0_val, o_data_kn1_val, o_data_kn2_val, o_data_kn3_val;
    logic          i_pe_ready;
    logic          o_data_req, o_busy, o_done, o_err;

    weight_buffer_ctrl dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_cfg_base_addr(i_cfg_base_addr), .i_cfg_num_grp(i_cfg_num_grp),
        .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr),
        .i_mem_rd_data(i_mem_rd_data), .i_mem_rd_val(i_mem_rd_val),
        .o_data_kn0(o_data_kn0), .o_data_kn1(o_data_kn1),
        .o_data_kn2(o_data_kn2), .o_data_kn3(o_data_kn3),
        .o_data_kn0_val(o_data_kn0_val), .o_data_kn1_val(o_data_kn1_val),
        .o_data_kn2_val(o_data_kn2_val), .o_data_kn3_val(o_data_kn3_val),
        .i_pe_ready(i_pe_ready), .o_data_req(o_data_req),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // stimulus-owned knobs
    int n_start = 0;
    int stray_n = 0;
    int lat_fixed = 2;      // 0 = random latency 1..4
    int ready_delay = 0;
    bit always_ready = 1'b1;

    // monitor-owned state
    int n_end = 0;
    bit grp_loaded = 1'b0;
    int vals_in_grp = 0;
    int req_in_seq = 0;
    bit busy_low_chk = 1'b0;
    bit ready_prev = 1'b0;

    logic [15:0]   exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    int            exp_done_ngrp[$];
    int            exp_done_cyc[$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Memory content: every 24-bit kernel slice differs per address.
    function automatic logic [DW-1:0] mem_word(input logic [15:0] a);
        logic [15:0] p, q;
        p = a + 16'h1234;
        q = a * 16'd7;
        return {a, ~a, p, a ^ 16'h5A5A, a[7:0], a[15:8], q};
    endfunction

    // Memory model: in-order returns with latency >= 1, plus stray beats on request.
    initial begin : memory
        logic [15:0] pend_addr[$];
        int          pend_due[$];
        int          last_due;
        int          stray_done;
        int          due;
        last_due = 0;
        stray_done = 0;
        i_mem_rd_val = 1'b0;
        i_mem_rd_data = '0;
        forever begin
            @(negedge clk);
            if (o_mem_rd_en && !rst) begin
                due = cyc + ((lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4)));
                if (due <= last_due) due = last_due + 1;
                pend_addr.push_back(o_mem_addr);
                pend_due.push_back(due);
                last_due = due;
            end
            @(posedge clk);
            #1;
            if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
                i_mem_rd_val = 1'b1;
                i_mem_rd_data = mem_word(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else if (stray_done != stray_n) begin
                i_mem_rd_val = 1'b1;
                i_mem_rd_data = {$urandom, $urandom, $urandom};
                stray_done++;
            end else begin
                i_mem_rd_val = 1'b0;
            end
        end
    end

    // PE ready driver: raise ready ready_delay cycles after a group is buffered.
    initial begin : pe_drv
        int rdy_cnt;
        rdy_cnt = 0;
        i_pe_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (always_ready) begin
                i_pe_ready = 1'b1;
            end else if (grp_loaded) begin
                if (rdy_cnt >= ready_delay) i_pe_ready = 1'b1;
                else rdy_cnt++;
            end else begin
                i_pe_ready = 1'b0;
                rdy_cnt = 0;
            end
        end
    end

    // Monitor
    initial begin : monitor
        logic [3:0] vals;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_addr_q.delete();
                exp_data_q.delete();
                exp_done_ngrp.delete();
                exp_done_cyc.delete();
                grp_loaded = 1'b0;
                vals_in_grp = 0;
                req_in_seq = 0;
                busy_low_chk = 1'b0;
                n_end = n_start;
            end else begin
                if (busy_low_chk) begin
                    chk("busy_after_done", DW'(o_busy), DW'(0));
                    busy_low_chk = 1'b0;
                end
                if (o_mem_rd_en) begin
                    chk("rd_expected", DW'(exp_addr_q.size() != 0), DW'(1));
                    if (exp_addr_q.size() != 0)
                        chk("rd_addr", DW'(o_mem_addr), DW'(exp_addr_q.pop_front()));
                end
                vals = {o_data_kn3_val, o_data_kn2_val, o_data_kn1_val, o_data_kn0_val};
                if (vals != 4'h0) begin
                    chk("kval_all", DW'(vals), DW'(4'hF));
                    chk("kval_vs_req", DW'(o_data_req), DW'(0));
                    chk("kval_expected", DW'(exp_data_q.size() != 0), DW'(1));
                    if (exp_data_q.size() != 0)
                        chk("kdata", {o_data_kn3, o_data_kn2, o_data_kn1, o_data_kn0},
                            exp_data_q.pop_front());
                    vals_in_grp++;
                    if (vals_in_grp == NROWS) grp_loaded = 1'b1;
                end
                if (o_data_req) begin
                    chk("req_rows", DW'(vals_in_grp), DW'(NROWS));
                    chk("req_after_ready", DW'(ready_prev), DW'(1));
                    vals_in_grp = 0;
                    grp_loaded = 1'b0;
                    req_in_seq++;
                end
                if (o_done) begin
                    chk("done_expected", DW'(exp_done_ngrp.size() != 0), DW'(1));
                    chk("busy_at_done", DW'(o_busy), DW'(1));
                    if (exp_done_ngrp.size() != 0) begin
                        chk("done_reqs", DW'(req_in_seq), DW'(exp_done_ngrp.pop_front()));
                        if (exp_done_cyc[0] >= 0)
                            chk("done_cycle", DW'(cyc), DW'(exp_done_cyc[0]));
                        void'(exp_done_cyc.pop_front());
                    end
                    req_in_seq = 0;
                    busy_low_chk = 1'b1;
                    n_end++;
                end
            end
            ready_prev = i_pe_ready;
        end
    end

    // Reference model: group g row r lives at base + g*NROWS + r (mod 2^16).
    task automatic start_seq(input logic [15:0] b, input logic [7:0] n);
        logic [15:0] a;
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_cfg_base_addr = b;
        i_cfg_num_grp = n;
        if (n_start == n_end) begin
            for (int g = 0; g < int'(n); g++) begin
                for (int r = 0; r < NROWS; r++) begin
                    a = b + 16'(g * NROWS + r);
                    exp_addr_q.push_back(a);
                    exp_data_q.push_back(mem_word(a));
                end
            end
            exp_done_ngrp.push_back(int'(n));
            exp_done_cyc.push_back((n == 8'd0) ? cyc + 1 : -1);
            n_start++;
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int k;
        k = 0;
        while (n_start != n_end && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk("seq_timeout", DW'(n_start == n_end), DW'(1));
        repeat (2) @(negedge clk);
        chk("addr_q_empty", DW'(exp_addr_q.size()), DW'(0));
        chk("data_q_empty", DW'(exp_data_q.size()), DW'(0));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, DW'({o_mem_rd_en, o_mem_addr, o_data_kn3_val, o_data_kn2_val,
            o_data_kn1_val, o_data_kn0_val, o_data_req, o_busy, o_done, o_err}), DW'(0));
        chk({nm, "_data"}, {o_data_kn3, o_data_kn2, o_data_kn1, o_data_kn0}, DW'(0));
    endtask

    initial begin : stim
        int k;
        logic [15:0] rb;
        logic [7:0]  rn;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single group, latency 2, always ready
        lat_fixed = 2;
        always_ready = 1'b1;
        start_seq(16'h0010, 8'd1);
        wait_idle(200);

        // zero groups: no reads, done one cycle after start
        start_seq(16'h0050, 8'd0);
        wait_idle(50);

        // address wrap
        lat_fixed = 0;
        start_seq(16'hFFFE, 8'd1);
        wait_idle(200);

        // three groups, ready held off five cycles per group
        always_ready = 1'b0;
        ready_delay = 5;
        start_seq(16'h0010, 8'd3);
        wait_idle(400);

        // randomized sequences
        for (int i = 0; i < 12; i++) begin
            rb = 16'($urandom);
            rn = 8'($urandom_range(0, 4));
            lat_fixed = int'($urandom_range(0, 3));
            ready_delay = int'($urandom_range(0, 6));
            always_ready = 1'($urandom_range(0, 1));
            start_seq(rb, rn);
            wait_idle(600);
        end
        chk("err_clean", DW'(o_err), DW'(0));

        // extra start while fetching is ignored, stray beat in idle sets o_err
        lat_fixed = 3;
        always_ready = 1'b0;
        ready_delay = 2;
        start_seq(16'h0100, 8'd1);
        start_seq(16'h0200, 8'd2);
        wait_idle(200);
        stray_n++;
        repeat (4) @(negedge clk);
        chk("err_after_stray", DW'(o_err), DW'(1));
        repeat (6) @(negedge clk);
        chk("err_sticky", DW'(o_err), DW'(1));

        // reset while waiting on the PE in group 0 of 2
        lat_fixed = 0;
        ready_delay = 1000;
        start_seq(16'h0040, 8'd2);
        k = 0;
        while (!grp_loaded && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("grp_loaded_timeout", DW'(grp_loaded), DW'(1));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("mid_reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_after_abort", DW'(o_busy), DW'(0));
        chk("err_after_abort", DW'(o_err), DW'(0));
        ready_delay = 0;
        start_seq(16'h0300, 8'd1);
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_buffer_ctrl.md
WEIGHT_BUFFER_CTRL -- requirements
Module: weight_buffer_ctrl

Interface
REQ-001 Parameters SHALL be: DAT_WIDTH, 8, bits per weight; NUM_KERNEL, 4, kernels loaded in parallel; NUM_CHANNEL, 3, channels per weight word; NUM_RDATA, 3, rows per kernel group; ADDR_WIDTH, 16, memory address width; GRP_WIDTH, 8, kernel-group count width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports follow.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 i_start  in  1  one-cycle pulse; begins a load sequence.
REQ-006 i_cfg_base_addr  in  ADDR_WIDTH  first weight-row address, sampled on accepted i_start.
REQ-007 i_cfg_num_grp  in  GRP_WIDTH  number of kernel groups, sampled on accepted i_start.
REQ-008 o_mem_rd_en  out  1  memory read strobe, one row per cycle.
REQ-009 o_mem_addr  out  ADDR_WIDTH  read address, valid with o_mem_rd_en.
REQ-010 i_mem_rd_data  in  DAT_WIDTH*NUM_CHANNEL*NUM_KERNEL  returned row; kernel k at bits [24k+23:24k] for default parameters.
REQ-011 i_mem_rd_val  in  1  return beat valid; in order, arbitrary latency of 1 cycle or more.
REQ-012 o_data_kn0..o_data_kn3  out  DAT_WIDTH*NUM_CHANNEL each  per-kernel row to the weight buffer.
REQ-013 o_data_kn0_val..o_data_kn3_val  out  1 each  per-kernel shift-in strobes.
REQ-014 i_pe_ready  in  1  compute engine ready to consume a full kernel group.
REQ-015 o_data_req  out  1  one-cycle pulse releasing buffered weights to the PEs.
REQ-016 o_busy  out  1  high whenever state is not IDLE.
REQ-017 o_done  out  1  one-cycle pulse at end of sequence.
REQ-018 o_err  out  1  sticky; set when i_mem_rd_val arrives outside FETCH.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, WAIT_PE, ISSUE and DONE.
REQ-020 IDLE: on i_start, go to FETCH if i_cfg_num_grp is nonzero, otherwise go to DONE; clear group counter; load address from base.
REQ-021 FETCH: assert o_mem_rd_en for exactly NUM_RDATA consecutive cycles from FETCH entry; o_mem_addr increments by 1 per issued read.
REQ-022 FETCH: count accepted i_mem_rd_val beats; on the NUM_RDATA-th beat go to WAIT_PE next cycle.
REQ-023 Each accepted beat SHALL register all four kernel slices to o_data_knK and pulse all o_data_knK_val one cycle later (latency 1).
REQ-024 WAIT_PE: hold until i_pe_ready=1, then go to ISSUE; i_pe_ready is not sampled in any other state.
REQ-025 ISSUE: o_data_req=1 for exactly this one cycle; increment group counter.
REQ-026 ISSUE exit: go to DONE if the incremented count equals the latched num_grp, otherwise go to FETCH.
REQ-027 Group g, row r SHALL be read from base + g*NUM_RDATA + r; the address is not reset between groups.
REQ-028 DONE: o_done=1 for one cycle, then go to IDLE.
REQ-029 i_start while o_busy=1 SHALL be ignored.
REQ-030 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; no overflow flag.
REQ-031 A beat outside FETCH, or beyond NUM_RDATA in a group, SHALL be dropped with no kernel val; o_err is set.
REQ-032 An o_data_knK_val pulse SHALL never coincide with o_data_req.

Reset
REQ-033 With rst=1 the block SHALL enter IDLE; all counters, the address and o_err clear to 0.
REQ-034 With rst=1 every output SHALL be 0 on the next edge.
REQ-035 Reset mid-sequence SHALL abort with no o_done; beats returning after reset are dropped and set o_err.

Verification
REQ-036 Single group: base=0x0010, num_grp=1, memory latency 2, i_pe_ready=1 -> reads at 0x10/0x11/0x12; 3 val pulses; one o_data_req; o_done; o_busy low afterwards.
REQ-037 Three groups with i_pe_ready low for 5 cycles per group -> addresses 0x10..0x18 in order; o_data_req only after ready; exactly 3 o_data_req pulses, then o_done.
REQ-038 num_grp=0 -> no o_mem_rd_en; o_done exactly 1 cycle after i_start.
REQ-039 Extra i_start during FETCH; a stray i_mem_rd_val in IDLE -> second start ignored; the stray beat produces no kernel val and o_err=1 until rst.
REQ-040 rst asserted in WAIT_PE of group 1 of 2 -> all outputs 0; no o_done; a new i_start after reset restarts from the new base.
REQ-041 base=0xFFFE, num_grp=1 -> reads at 0xFFFE, 0xFFFF, 0x0000.
